// File: rtl/serial_add_pkg.sv
// Shared types and constants for the 2-bit-per-cycle serial adder.
// Holds the controller state enum and the slice width.
package serial_add_pkg;

    localparam int SLICE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add2_slice.sv
// Combinational 2-bit adder slice with carry in/out.
// Ports: a, b (2-bit operands), ci (carry in) -> s (2-bit sum), co (carry out).
import serial_add_pkg::*;

module add2_slice (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    always_comb begin
        {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, ci};
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Serial adder controller: accepts A, B, cin and adds 2 bits per cycle.
// Ports: start_valid/start_ready (request), a/b/cin (operands),
// busy, done_valid/done_ready (result handshake), sum/cout (registered result).
import serial_add_pkg::*;

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NSLICE - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [SLICE_W-1:0] sl_a, sl_b, sl_s;
    logic               sl_co;

    // Bit offset of the current slice: idx * 2.
    logic [IDX_W:0] bit_off;
    assign bit_off = {idx_q, 1'b0};

    assign sl_a = a_q[bit_off +: SLICE_W];
    assign sl_b = b_q[bit_off +: SLICE_W];

    add2_slice u_slice (
        .a  (sl_a),
        .b  (sl_b),
        .ci (carry_q),
        .s  (sl_s),
        .co (sl_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[bit_off +: SLICE_W] = sl_s;
                carry_d = sl_co;
                if (idx_q == LAST) begin
                    // Index parks on the last slice rather than wrapping.
                    cout_d  = sl_co;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q == RUN);
    assign done_valid  = (state_q == DONE);
    assign sum         = sum_q;
    assign cout        = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8).
// Directed corner cases plus randomized operations against an arithmetic model.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;
    localparam int LAT   = WIDTH / 2;

    logic             clk;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done_valid;
    logic             done_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_checks = 0;
    int n_errors = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .cin         (cin),
        .busy        (busy),
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .sum         (sum),
        .cout        (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation; hold = cycles done_ready stays low in DONE.
    task automatic run_op(input logic [WIDTH-1:0] op_a,
                          input logic [WIDTH-1:0] op_b,
                          input logic op_c, input int hold);
        logic [WIDTH:0] exp;
        int n;
        exp = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_c};
        a = op_a;
        b = op_b;
        cin = op_c;
        start_valid = 1'b1;
        n = 0;
        while (!start_ready && n < 20) begin
            step();
            n++;
        end
        check("start_ready_idle", start_ready, 1);
        step();
        start_valid = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        cin = 1'($urandom);
        check("busy_after_accept", busy, 1);
        check("sum_cleared", sum, 0);
        n = 0;
        while (!done_valid && n < 20) begin
            done_ready = 1'($urandom);
            step();
            n++;
        end
        done_ready = 1'b0;
        check("latency", n, LAT);
        check("sum", sum, exp[WIDTH-1:0]);
        check("cout", cout, exp[WIDTH]);
        check("busy_done", busy, 0);
        for (int i = 0; i < hold; i++) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            start_valid = 1'($urandom);
            step();
            check("hold_sum", sum, exp[WIDTH-1:0]);
            check("hold_cout", cout, exp[WIDTH]);
            check("hold_ready", start_ready, 0);
            check("hold_valid", done_valid, 1);
        end
        start_valid = 1'b0;
        done_ready = 1'b1;
        step();
        done_ready = 1'b0;
        check("back_idle", start_ready, 1);
        check("valid_low", done_valid, 0);
        check("idle_sum", sum, exp[WIDTH-1:0]);
        check("idle_cout", cout, exp[WIDTH]);
    endtask

    initial begin
        int cyc;
        int prev_acc;
        int n_acc;
        logic prev_busy;

        rst_n = 1'b0;
        start_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        done_ready = 1'b0;
        #12;
        check("rst_ready", start_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", done_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_op(8'h0F, 8'h01, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'hAA, 8'h55, 1'b1, 0);
        run_op(8'h00, 8'h00, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 3);

        // Continuous start_valid: accepts spaced LAT+2 edges apart.
        a = 8'h33;
        b = 8'h44;
        cin = 1'b0;
        start_valid = 1'b1;
        done_ready = 1'b1;
        prev_busy = busy;
        prev_acc = -1;
        n_acc = 0;
        for (cyc = 0; cyc < 30; cyc++) begin
            step();
            if (busy && !prev_busy) begin
                if (prev_acc >= 0)
                    check("accept_spacing", cyc - prev_acc, LAT + 2);
                prev_acc = cyc;
                n_acc++;
            end
            if (done_valid) begin
                check("cont_sum", sum, 8'h77);
                check("cont_cout", cout, 0);
            end
            prev_busy = busy;
        end
        check("accept_count", n_acc >= 4, 1);
        start_valid = 1'b0;
        done_ready = 1'b0;
        for (int i = 0; i < 10 && !start_ready; i++) begin
            done_ready = 1'b1;
            step();
        end
        done_ready = 1'b0;
        check("cont_idle", start_ready, 1);

        // Reset mid-RUN at slice index 2.
        a = 8'h5A;
        b = 8'h3C;
        start_valid = 1'b1;
        step();
        start_valid = 1'b0;
        step();
        step();
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mrst_sum", sum, 0);
        check("mrst_cout", cout, 0);
        check("mrst_busy", busy, 0);
        check("mrst_ready", start_ready, 1);
        check("mrst_valid", done_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h12, 8'h34, 1'b0, 0);

        for (int i = 0; i < 25; i++) begin
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
